// File: rtl/apb_intercon_rr_if.sv
// Per-master APB ports plus the shared peripheral bus of apb_intercon_rr.
// Handshake: a master requests by raising S_PSELx and holds S_PADDR/S_PWRITE/S_PWDATA stable until it sees S_PREADY.
interface apb_intercon_rr_if #(
    parameter int MASTER_PORTS = 2,
    parameter int SLAVE_PORTS  = 8,
    parameter int BUS_WIDTH    = 16
);
    logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR;
    logic [MASTER_PORTS-1:0]           S_PWRITE;
    logic [MASTER_PORTS-1:0]           S_PSELx;
    logic [MASTER_PORTS-1:0]           S_PENABLE;
    logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA;
    logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA;
    logic [MASTER_PORTS-1:0]           S_PREADY;
    logic [MASTER_PORTS-1:0]           S_PSLVERR;
    logic [BUS_WIDTH-1:0]              M_PADDR;
    logic                              M_PWRITE;
    logic                              M_PENABLE;
    logic [SLAVE_PORTS-1:0]            M_PSELx;
    logic [BUS_WIDTH-1:0]              M_PWDATA;
    logic [BUS_WIDTH-1:0]              M_PRDATA;
    logic                              M_PREADY;
    logic [1:0]                        dbg_state;

    modport slave (
        input  S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA, M_PRDATA, M_PREADY,
        output S_PRDATA, S_PREADY, S_PSLVERR, M_PADDR, M_PWRITE, M_PENABLE, M_PSELx,
               M_PWDATA, dbg_state
    );

    modport master (
        output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA, M_PRDATA, M_PREADY,
        input  S_PRDATA, S_PREADY, S_PSLVERR, M_PADDR, M_PWRITE, M_PENABLE, M_PSELx,
               M_PWDATA, dbg_state
    );
endinterface

// File: rtl/apb_intercon_rr.sv
// Round-robin arbiter of MASTER_PORTS APB masters onto one shared APB bus with
// address-field slave decode, decode-error and timeout responses via S_PSLVERR.
module apb_intercon_rr #(
    parameter int MASTER_PORTS = 2,
    parameter int SLAVE_PORTS  = 8,
    parameter int BUS_WIDTH    = 16,
    parameter int SEL_LSB      = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    apb_intercon_rr_if.slave       bus
);
    localparam int SEL_W  = (SLAVE_PORTS > 1) ? $clog2(SLAVE_PORTS) : 1;
    localparam int GNT_W  = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;
    localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int HI_W   = BUS_WIDTH - SEL_LSB;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [GNT_W-1:0]    grant_q, grant_d;
    logic [GNT_W-1:0]    rr_last_q, rr_last_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;

    logic                req_any;
    logic [GNT_W-1:0]    winner;
    logic [GNT_W-1:0]    cand;
    logic [BUS_WIDTH-1:0] m_paddr, m_pwdata;
    logic                m_pwrite;
    logic [HI_W-1:0]     sel_hi;
    logic [SEL_W-1:0]    idx;
    logic                dec_err;
    logic [SLAVE_PORTS-1:0] m_psel;
    logic                gnt_psel, timeout, done, err;
    logic [MASTER_PORTS*BUS_WIDTH-1:0] s_prdata;
    logic [MASTER_PORTS-1:0] s_pready, s_pslverr;
    logic                unused_penable;

    assign unused_penable = ^bus.S_PENABLE;

    // Scan upward from the master after the last winner, wrapping around.
    always_comb begin
        req_any = 1'b0;
        winner  = '0;
        cand    = '0;
        for (int k = 1; k <= MASTER_PORTS; k++) begin
            cand = GNT_W'((int'(rr_last_q) + k) % MASTER_PORTS);
            if (!req_any && bus.S_PSELx[cand]) begin
                req_any = 1'b1;
                winner  = cand;
            end
        end
    end

    always_comb begin
        m_paddr  = '0;
        m_pwdata = '0;
        m_pwrite = 1'b0;
        if (state_q != ST_IDLE) begin
            m_paddr  = bus.S_PADDR[int'(grant_q)*BUS_WIDTH +: BUS_WIDTH];
            m_pwdata = bus.S_PWDATA[int'(grant_q)*BUS_WIDTH +: BUS_WIDTH];
            m_pwrite = bus.S_PWRITE[grant_q];
        end
    end

    // Address bits above the select field take part in the decode, so an address
    // beyond the populated window errors out instead of aliasing onto a slave.
    always_comb begin
        sel_hi  = m_paddr[BUS_WIDTH-1:SEL_LSB];
        idx     = m_paddr[SEL_LSB +: SEL_W];
        dec_err = (int'(sel_hi) >= SLAVE_PORTS);
        m_psel  = '0;
        if (state_q != ST_IDLE && !dec_err) m_psel[idx] = 1'b1;
    end

    always_comb begin
        gnt_psel = bus.S_PSELx[grant_q];
        timeout  = (state_q == ST_ACCESS) && (TIMEOUT != 0) &&
                   (int'(tcnt_q) == TIMEOUT - 1) && !bus.M_PREADY;
        done     = (state_q == ST_ACCESS) && gnt_psel &&
                   (bus.M_PREADY || dec_err || timeout);
        err      = dec_err || timeout;
    end

    always_comb begin
        s_prdata  = '0;
        s_pready  = '0;
        s_pslverr = '0;
        if (done) begin
            s_pready[grant_q]  = 1'b1;
            s_pslverr[grant_q] = err;
            s_prdata[int'(grant_q)*BUS_WIDTH +: BUS_WIDTH] = err ? '0 : bus.M_PRDATA;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        tcnt_d    = tcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    grant_d   = winner;
                    rr_last_d = winner;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                tcnt_d  = '0;
                state_d = gnt_psel ? ST_ACCESS : ST_IDLE;
            end
            ST_ACCESS: begin
                tcnt_d = tcnt_q + TCNT_W'(1);
                if (!gnt_psel || done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_last_q <= GNT_W'(MASTER_PORTS - 1);
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign bus.M_PADDR   = m_paddr;
    assign bus.M_PWDATA  = m_pwdata;
    assign bus.M_PWRITE  = m_pwrite;
    assign bus.M_PENABLE = (state_q == ST_ACCESS);
    assign bus.M_PSELx   = m_psel;
    assign bus.S_PRDATA  = s_prdata;
    assign bus.S_PREADY  = s_pready;
    assign bus.S_PSLVERR = s_pslverr;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_apb_intercon_rr.sv
// Bench for apb_intercon_rr: directed timing checks plus randomized multi-master
// traffic scored against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_apb_intercon_rr;
    localparam int NM = 2;
    localparam int NS = 8;
    localparam int BW = 16;
    localparam int SL = 8;
    localparam int TO = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    apb_intercon_rr_if #(.MASTER_PORTS(NM), .SLAVE_PORTS(NS), .BUS_WIDTH(BW)) bus ();
    apb_intercon_rr_if #(.MASTER_PORTS(NM), .SLAVE_PORTS(NS), .BUS_WIDTH(BW)) bus_nt ();

    apb_intercon_rr #(
        .MASTER_PORTS(NM), .SLAVE_PORTS(NS), .BUS_WIDTH(BW), .SEL_LSB(SL), .TIMEOUT(TO)
    ) u_dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    apb_intercon_rr #(
        .MASTER_PORTS(NM), .SLAVE_PORTS(NS), .BUS_WIDTH(BW), .SEL_LSB(SL), .TIMEOUT(0)
    ) u_dut_nt (
        .clk(clk), .reset(reset), .bus(bus_nt.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    int model_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- slave behaviour ----------------
    // Wait states come from address bits [6:4]; read data is a fixed function of address and wdata.
    function automatic logic [2:0] wait_of(input logic [15:0] a);
        return a[6:4];
    endfunction

    function automatic logic [15:0] rdata_of(input logic [15:0] a, input logic [15:0] wd);
        return a ^ 16'hBFEB ^ wd;
    endfunction

    int acc_n;
    initial begin
        bus.M_PREADY = 1'b0;
        bus.M_PRDATA = '0;
        acc_n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.M_PENABLE && |bus.M_PSELx) begin
                bus.M_PREADY = (acc_n >= int'(wait_of(bus.M_PADDR)));
                bus.M_PRDATA = rdata_of(bus.M_PADDR, bus.M_PWDATA);
                acc_n++;
            end else begin
                bus.M_PREADY = 1'b0;
                bus.M_PRDATA = 16'hDEAD;
                acc_n = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_m(input int m, input logic sel, input logic wr,
                           input logic [15:0] a, input logic [15:0] wd);
        bus.S_PSELx[m]            = sel;
        bus.S_PENABLE[m]          = sel;
        bus.S_PWRITE[m]           = wr;
        bus.S_PADDR[m*BW +: BW]   = a;
        bus.S_PWDATA[m*BW +: BW]  = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model / scoreboard ----------------
    // Record: {master[2], err, access_cycles[4], psel[8], rdata[16], addr[16], write, wdata[16]}
    logic [63:0] exp_q[$];
    logic [32:0] txq[NM][$];

    function automatic logic [63:0] exp_rec(input int m, input logic [32:0] t);
        logic        wr, dec, tmo;
        logic [15:0] a, wd, rd;
        logic [7:0]  ps;
        int          sel, wt, nacc;
        wr   = t[32];
        a    = t[31:16];
        wd   = t[15:0];
        sel  = int'(a >> SL);
        wt   = int'(wait_of(a));
        dec  = (sel >= NS);
        tmo  = !dec && (wt >= TO);
        nacc = dec ? 1 : (tmo ? TO : wt + 1);
        ps   = dec ? 8'h00 : 8'(1 << sel);
        rd   = (dec || tmo) ? 16'h0000 : rdata_of(a, wd);
        return {2'(m), dec || tmo, 4'(nacc), ps, rd, a, wr, wd};
    endfunction

    // Every master with work left is requesting at each arbitration point,
    // so the completion order follows from the queues alone.
    task automatic model_build();
        int pos[NM];
        for (int m = 0; m < NM; m++) pos[m] = 0;
        while (1) begin
            int w;
            w = -1;
            for (int k = 1; k <= NM; k++) begin
                int c;
                c = (model_last + k) % NM;
                if (w < 0 && pos[c] < txq[c].size()) w = c;
            end
            if (w < 0) break;
            exp_q.push_back(exp_rec(w, txq[w][pos[w]]));
            pos[w]++;
            model_last = w;
        end
    endtask

    task automatic run_engine(input int budget);
        logic [63:0] e;
        logic [31:0] ev;
        logic        adv[NM];
        int          nacc, cyc, obs_m, em;
        model_build();
        tick();
        for (int m = 0; m < NM; m++) begin
            if (txq[m].size() > 0) drive_m(m, 1'b1, txq[m][0][32], txq[m][0][31:16], txq[m][0][15:0]);
            else drive_m(m, 1'b0, 1'b0, 16'h0, 16'h0);
        end
        nacc = 0;
        cyc  = 0;
        while (exp_q.size() > 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            for (int m = 0; m < NM; m++) adv[m] = 1'b0;
            if (bus.M_PENABLE) nacc++;
            if (|bus.S_PREADY) begin
                e  = exp_q.pop_front();
                em = int'(e[63:62]);
                obs_m = 0;
                for (int m = NM - 1; m >= 0; m--) if (bus.S_PREADY[m]) obs_m = m;
                chk("rr_grant", 32'(bus.S_PREADY), 32'(1) << em);
                chk("rsp_slverr", 32'(bus.S_PSLVERR), e[61] ? (32'(1) << em) : 32'h0);
                ev = '0;
                ev[em*BW +: BW] = e[48:33];
                chk("rsp_rdata", bus.S_PRDATA, ev);
                chk("access_cycles", 32'(nacc), 32'(e[60:57]));
                chk("bus_psel", 32'(bus.M_PSELx), 32'(e[56:49]));
                chk("bus_paddr", 32'(bus.M_PADDR), 32'(e[32:17]));
                chk("bus_pwrite", 32'(bus.M_PWRITE), 32'(e[16]));
                chk("bus_pwdata", 32'(bus.M_PWDATA), 32'(e[15:0]));
                nacc = 0;
                adv[obs_m] = 1'b1;
            end
            tick();
            for (int m = 0; m < NM; m++) begin
                if (adv[m]) begin
                    if (txq[m].size() > 0) void'(txq[m].pop_front());
                    if (txq[m].size() > 0)
                        drive_m(m, 1'b1, txq[m][0][32], txq[m][0][31:16], txq[m][0][15:0]);
                    else
                        drive_m(m, 1'b0, 1'b0, 16'h0, 16'h0);
                end
            end
        end
        chk("engine_drained", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        for (int m = 0; m < NM; m++) begin
            txq[m].delete();
            drive_m(m, 1'b0, 1'b0, 16'h0, 16'h0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        bus.S_PSELx = '0; bus.S_PENABLE = '0; bus.S_PWRITE = '0;
        bus.S_PADDR = '0; bus.S_PWDATA = '0;
        bus_nt.S_PSELx = '0; bus_nt.S_PENABLE = '0; bus_nt.S_PWRITE = '0;
        bus_nt.S_PADDR = '0; bus_nt.S_PWDATA = '0;
        bus_nt.M_PREADY = 1'b0; bus_nt.M_PRDATA = 16'h1357;
        model_last = NM - 1;

        #12;
        chk("rst_psel", 32'(bus.M_PSELx), 32'h0);
        chk("rst_penable", 32'(bus.M_PENABLE), 32'h0);
        chk("rst_paddr", 32'(bus.M_PADDR), 32'h0);
        chk("rst_pready", 32'(bus.S_PREADY), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Zero-wait read by master 0
        tick(); drive_m(0, 1'b1, 1'b0, 16'h0104, 16'h0000);
        @(negedge clk); chk("zw_c0_psel", 32'(bus.M_PSELx), 32'h0);
        tick(); @(negedge clk);
        chk("zw_c1_psel", 32'(bus.M_PSELx), 32'h02);
        chk("zw_c1_penable", 32'(bus.M_PENABLE), 32'h0);
        tick(); @(negedge clk);
        chk("zw_c2_psel", 32'(bus.M_PSELx), 32'h02);
        chk("zw_c2_penable", 32'(bus.M_PENABLE), 32'h1);
        chk("zw_c2_pready", 32'(bus.S_PREADY), 32'h1);
        chk("zw_c2_prdata", bus.S_PRDATA, 32'h0000_BEEF);
        chk("zw_c2_slverr", 32'(bus.S_PSLVERR), 32'h0);
        tick(); drive_m(0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        chk("zw_c3_idle_pen", 32'(bus.M_PENABLE), 32'h0);
        chk("zw_c3_idle_psel", 32'(bus.M_PSELx), 32'h0);
        model_last = 0;

        // Decode error: master 1 writes outside the slave window
        tick(); drive_m(1, 1'b1, 1'b1, 16'h0A00, 16'h1234);
        tick(); @(negedge clk);
        chk("dec_c1_psel", 32'(bus.M_PSELx), 32'h0);
        chk("dec_c1_paddr", 32'(bus.M_PADDR), 32'h0A00);
        chk("dec_c1_pwrite", 32'(bus.M_PWRITE), 32'h1);
        tick(); @(negedge clk);
        chk("dec_c2_psel", 32'(bus.M_PSELx), 32'h0);
        chk("dec_c2_pready", 32'(bus.S_PREADY), 32'h2);
        chk("dec_c2_slverr", 32'(bus.S_PSLVERR), 32'h2);
        chk("dec_c2_prdata", bus.S_PRDATA, 32'h0);
        tick(); drive_m(1, 1'b0, 1'b0, 16'h0, 16'h0);
        model_last = 1;

        // Timeout: slave never ready (wait field 7)
        tick(); drive_m(0, 1'b1, 1'b0, 16'h0170, 16'h0000);
        tick();
        for (int a = 1; a <= TO; a++) begin
            tick(); @(negedge clk);
            if (a < TO) begin
                chk("to_early_pready", 32'(bus.S_PREADY), 32'h0);
            end else begin
                chk("to_pready", 32'(bus.S_PREADY), 32'h1);
                chk("to_slverr", 32'(bus.S_PSLVERR), 32'h1);
                chk("to_prdata", bus.S_PRDATA, 32'h0);
            end
        end
        tick(); drive_m(0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk); chk("to_after_psel", 32'(bus.M_PSELx), 32'h0);
        model_last = 0;

        // Three wait states: ready on ACCESS cycle 4
        tick(); drive_m(1, 1'b1, 1'b0, 16'h0230, 16'h0000);
        tick();
        for (int a = 1; a <= 4; a++) begin
            tick(); @(negedge clk);
            if (a < 4) begin
                chk("ws_early_pready", 32'(bus.S_PREADY), 32'h0);
            end else begin
                chk("ws_pready", 32'(bus.S_PREADY), 32'h2);
                chk("ws_slverr", 32'(bus.S_PSLVERR), 32'h0);
                chk("ws_prdata", bus.S_PRDATA, {16'hBDDB, 16'h0000});
            end
        end
        tick(); drive_m(1, 1'b0, 1'b0, 16'h0, 16'h0);
        model_last = 1;

        // TIMEOUT=0 instance waits indefinitely, then the master aborts
        bus_nt.S_PSELx = 2'b01; bus_nt.S_PENABLE = 2'b01; bus_nt.S_PADDR = 32'h0000_0100;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("nt_still_access", 32'(bus_nt.M_PENABLE), 32'h1);
        chk("nt_no_ready", 32'(bus_nt.S_PREADY), 32'h0);
        chk("nt_psel", 32'(bus_nt.M_PSELx), 32'h02);
        tick(); bus_nt.S_PSELx = '0; bus_nt.S_PENABLE = '0;
        @(negedge clk); chk("nt_abort_no_rsp", 32'(bus_nt.S_PREADY), 32'h0);
        tick(); @(negedge clk);
        chk("nt_abort_psel", 32'(bus_nt.M_PSELx), 32'h0);
        chk("nt_abort_pen", 32'(bus_nt.M_PENABLE), 32'h0);

        // Asynchronous reset in the middle of ACCESS
        tick(); drive_m(0, 1'b1, 1'b1, 16'h0170, 16'hA5A5);
        tick(); tick(); @(negedge clk);
        chk("rm_in_access", 32'(bus.M_PENABLE), 32'h1);
        #2; reset = 1'b0; #1;
        chk("rm_psel", 32'(bus.M_PSELx), 32'h0);
        chk("rm_penable", 32'(bus.M_PENABLE), 32'h0);
        chk("rm_paddr", 32'(bus.M_PADDR), 32'h0);
        chk("rm_pwrite", 32'(bus.M_PWRITE), 32'h0);
        chk("rm_pwdata", 32'(bus.M_PWDATA), 32'h0);
        chk("rm_pready", 32'(bus.S_PREADY), 32'h0);
        chk("rm_slverr", 32'(bus.S_PSLVERR), 32'h0);
        chk("rm_prdata", bus.S_PRDATA, 32'h0);
        drive_m(0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_last = NM - 1;

        // Both masters request continuously: grants must alternate starting at master 0
        for (int i = 0; i < 3; i++) begin
            txq[0].push_back({1'b0, 16'h0104 + 16'(i), 16'h0000});
            txq[1].push_back({1'b1, 16'h0300 + 16'(i), 16'h1111 * 16'(i + 1)});
        end
        run_engine(200);

        // Randomized traffic: mix of slaves, wait states, decode errors and timeouts
        for (int r = 0; r < 6; r++) begin
            for (int m = 0; m < NM; m++) begin
                int n;
                n = $urandom_range(0, 5);
                for (int i = 0; i < n; i++) begin
                    logic [15:0] a;
                    a = {8'($urandom_range(0, 9)), 1'($urandom_range(0, 1)),
                         3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
                    txq[m].push_back({1'($urandom_range(0, 1)), a, 16'($urandom)});
                end
            end
            run_engine(500);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected finish");
        $fatal(1);
    end
endmodule
